// File: rtl/timer_arbiter.sv
// timer_arbiter: one shared W-bit up-counting timer handed out to N requesters
// in round-robin order. The owner gets a one-cycle done pulse when its latched
// delay has elapsed; dropping the request early releases the timer silently.
module timer_arbiter #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] delay,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic [W-1:0]   count,
  output logic [N-1:0]   done
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t          state_q;
  logic [N-1:0]    grant_q;
  logic            busy_q;
  logic [W-1:0]    count_q;
  logic [N-1:0]    done_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   sel_q;
  logic [W-1:0]    target_q;

  logic [PW-1:0]   sel_d;
  logic            sel_found;
  logic [PW-1:0]   scan_idx;
  logic [W-1:0]    delay_arr [N];

  // Modulo-N increment of a requester index (N need not be a power of two).
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] p);
    if (p == PW'(N - 1)) return '0;
    else                 return p + PW'(1);
  endfunction

  // Unpack the flat delay bus into one word per requester.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      delay_arr[i] = delay[i*W +: W];
    end
  end

  // Round-robin pick: first asserted request scanning ptr, ptr+1, ... mod N.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned and infers a latch.
    sel_d     = '0;
    sel_found = 1'b0;
    scan_idx  = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (!sel_found && req[scan_idx]) begin
        sel_found = 1'b1;
        sel_d     = scan_idx;
      end
      scan_idx = next_idx(scan_idx);
    end
  end

  // Arbitration / timing FSM; every output comes straight from a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      count_q  <= '0;
      done_q   <= '0;
      ptr_q    <= '0;
      sel_q    <= '0;
      target_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_found) begin
            sel_q    <= sel_d;
            target_q <= delay_arr[sel_d];
            grant_q  <= N'(1) << sel_d;
            busy_q   <= 1'b1;
            count_q  <= '0;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!req[sel_q]) begin
            // Owner withdrew: release without a done pulse, owner drops to lowest priority.
            state_q <= ST_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            ptr_q   <= next_idx(sel_q);
          end else if (count_q == target_q) begin
            // count holds at target, so it never wraps even for an all-ones delay.
            state_q <= ST_DONE;
            done_q  <= grant_q;
          end else begin
            count_q <= count_q + W'(1);
          end
        end
        ST_DONE: begin
          // Single-cycle pulse; the owner's request is not looked at here.
          state_q <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= '0;
          count_q <= '0;
          ptr_q   <= next_idx(sel_q);
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= '0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign count = count_q;
  assign done  = done_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter: stimulus pushes the grant/done/abort
// events it expects; a negedge monitor detects those events on the DUT and
// pops/compares them, and also checks per-cycle invariants.
module tb_timer_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] delay;
  logic [N-1:0]   grant;
  logic           busy;
  logic [W-1:0]   count;
  logic [N-1:0]   done;

  timer_arbiter #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .delay (delay),
    .grant (grant),
    .busy  (busy),
    .count (count),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {EV_GRANT, EV_DONE, EV_ABORT} ev_e;
  typedef struct {
    ev_e        kind;
    logic [3:0] vec;   // grant for GRANT/ABORT, done for DONE
    logic [31:0] cnt;  // count seen in that cycle
    int         lat;   // GRANT: idle cycles before it; DONE/ABORT: cycles since grant; -1 = skip
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input ev_e kind, input logic [3:0] vec, input logic [31:0] cnt, input int lat);
    exp_t e;
    e.kind = kind; e.vec = vec; e.cnt = cnt; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic ev_check(input ev_e kind, input logic [3:0] vec, input logic [31:0] cnt, input int lat);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: got kind %0d vec 0x%0h, expected no event (t=%0t)", kind, vec, $time);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", 64'(kind), 64'(e.kind));
      check("ev_vec", 64'(vec), 64'(e.vec));
      check("ev_count", 64'(cnt), 64'(e.cnt));
      if (e.lat >= 0) check("ev_latency", 64'(lat), 64'(e.lat));
    end
  endtask

  // Monitor: turns DUT activity into events and checks invariants.
  logic [3:0] prev_grant = '0;
  logic [3:0] prev_done  = '0;
  int         age        = 0;
  int         idle_cnt   = 0;

  always @(negedge clk) begin
    if (grant != 4'b0 && prev_grant == 4'b0) begin
      age = 0;
      ev_check(EV_GRANT, grant, count, idle_cnt);
      idle_cnt = 0;
    end else begin
      age++;
    end
    if (done != 4'b0) ev_check(EV_DONE, done, count, age);
    if (grant == 4'b0 && prev_grant != 4'b0 && prev_done == 4'b0)
      ev_check(EV_ABORT, prev_grant, count, age);
    if (grant == 4'b0) idle_cnt++;
    check("busy_match", 64'(busy), 64'(|grant));
    check("done_owned", 64'(done & ~grant), 64'(0));
    if (grant != 4'b0 && done == 4'b0) check("count_age", 64'(count), 64'(age));
    if (grant == 4'b0) check("count_idle", 64'(count), 64'(0));
    prev_grant = grant;
    prev_done  = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_delay(input int idx, input logic [31:0] val);
    delay[idx*W +: W] = val;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) tick();
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL %s_timeout: got %0d events outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_count(input string name, input logic [31:0] val);
    int n = 0;
    while (count != val && n < 300) begin
      tick();
      n++;
    end
    if (count != val) begin
      n_total++;
      $display("FAIL %s_timeout: got count %0d, expected %0d", name, count, val);
    end
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    delay = '0;
    do_reset();

    // 1: single request, delay 5 -> done 6 cycles after grant, count reaches 5.
    set_delay(0, 5);
    req = 4'b0001;
    push(EV_GRANT, 4'b0001, 0, -1);
    push(EV_DONE,  4'b0001, 5, 6);
    wait_drain("t1");
    req = '0;

    // 2: delay 0 -> done one cycle after grant, count stays 0.
    do_reset();
    set_delay(2, 0);
    req = 4'b0100;
    push(EV_GRANT, 4'b0100, 0, -1);
    push(EV_DONE,  4'b0100, 0, 1);
    wait_drain("t2");
    req = '0;

    // 3: all requesting, delays 2 -> strict rotation with one idle cycle between grants.
    do_reset();
    for (int i = 0; i < N; i++) set_delay(i, 2);
    req = 4'b1111;
    push(EV_GRANT, 4'b0001, 0, -1); push(EV_DONE, 4'b0001, 2, 3);
    push(EV_GRANT, 4'b0010, 0, 1);  push(EV_DONE, 4'b0010, 2, 3);
    push(EV_GRANT, 4'b0100, 0, 1);  push(EV_DONE, 4'b0100, 2, 3);
    push(EV_GRANT, 4'b1000, 0, 1);  push(EV_DONE, 4'b1000, 2, 3);
    push(EV_GRANT, 4'b0001, 0, 1);  push(EV_DONE, 4'b0001, 2, 3);
    wait_drain("t3");
    req = '0;

    // 4: abort at count 3, then requester 1 loses to requester 2.
    do_reset();
    set_delay(1, 10);
    set_delay(2, 1);
    req = 4'b0010;
    push(EV_GRANT, 4'b0010, 0, -1);
    wait_count("t4_count", 3);
    req = '0;
    push(EV_ABORT, 4'b0010, 0, 4);
    tick();
    req = 4'b0110;
    push(EV_GRANT, 4'b0100, 0, 1);
    push(EV_DONE,  4'b0100, 1, 2);
    wait_drain("t4");
    req = '0;

    // 5: move ptr, then reset mid-run; afterwards ptr is back at 0.
    do_reset();
    set_delay(1, 0);
    req = 4'b0010;
    push(EV_GRANT, 4'b0010, 0, -1);
    push(EV_DONE,  4'b0010, 0, 1);
    wait_drain("t5a");
    req = '0;
    tick();
    set_delay(2, 10);
    req = 4'b0100;
    push(EV_GRANT, 4'b0100, 0, -1);
    wait_count("t5_count", 4);
    rst = 1'b1;
    req = '0;
    push(EV_ABORT, 4'b0100, 0, 5);
    tick();
    check("t5_grant", 64'(grant), 64'(0));
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_count", 64'(count), 64'(0));
    check("t5_done", 64'(done), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_delay(i, 0);
    req = 4'b1111;
    push(EV_GRANT, 4'b0001, 0, -1);
    push(EV_DONE,  4'b0001, 0, 1);
    wait_drain("t5b");
    req = '0;

    // 6: delay changed during RUN has no effect on the latched target.
    do_reset();
    set_delay(0, 3);
    req = 4'b0001;
    push(EV_GRANT, 4'b0001, 0, -1);
    push(EV_DONE,  4'b0001, 3, 4);
    begin
      int n = 0;
      while (!busy && n < 50) begin
        tick();
        n++;
      end
    end
    set_delay(0, 100);
    wait_drain("t6");
    req = '0;

    repeat (5) tick();
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
